// File: rtl/conv_out_pool_if.sv
// conv_out_pool_if: sample stream into and pooled pixel stream out of conv_out_pool.
//   master: valid_in, din, bias, shift driven; valid_out, dout, frame_done observed
//   slave : the pooling block, the reverse directions
interface conv_out_pool_if;
   logic               valid_in;
   logic signed [17:0] din;
   logic signed [7:0]  bias;
   logic        [3:0]  shift;
   logic               valid_out;
   logic signed [7:0]  dout;
   logic               frame_done;
   modport master (output valid_in, din, bias, shift, input valid_out, dout, frame_done);
   modport slave  (input valid_in, din, bias, shift, output valid_out, dout, frame_done);
endinterface

// File: rtl/conv_out_pool.sv
// conv_out_pool: bias + ReLU + round/shift requant of conv accumulator samples, then 2x2/stride-2 max pool.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of conv_out_pool_if (valid_in/din/bias/shift in, valid_out/dout/frame_done out)
//   Macro CONV_OUT_POOL_EN builds the pooling path; without it every requantized sample is emitted.
module conv_out_pool #(
   parameter int IMG_W = 12,
   parameter int IMG_H = 12
) (
   input logic          clk,
   input logic          rst_n,
   conv_out_pool_if.slave bus
);
   localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
   localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          w_col_last, w_row_last;
   logic [18:0]   w_sum;
   logic [19:0]   w_rnd, w_shr;
   logic [6:0]    w_q;
   logic          r_v1, r_last;
   logic [6:0]    r_q;
   logic          r_vout, r_fd;
   logic [7:0]    r_dout;
   assign w_col_last = r_col == CW'(IMG_W - 1);
   assign w_row_last = r_row == RW'(IMG_H - 1);
   // 19-bit sum cannot overflow; negative sums are clamped to zero before rounding
   assign w_sum = {bus.din[17], bus.din} + {{11{bus.bias[7]}}, bus.bias};
   assign w_rnd = {2'b00, w_sum[18] ? 18'd0 : w_sum[17:0]}
                + (bus.shift != 4'd0 ? 20'd1 << (bus.shift - 4'd1) : 20'd0);
   assign w_shr = w_rnd >> bus.shift;
   assign w_q   = |w_shr[19:7] ? 7'd127 : w_shr[6:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (bus.valid_in) begin
         r_col <= w_col_last ? '0 : r_col + 1'b1;
         if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_q    <= '0;
         r_last <= 1'b0;
      end else begin
         r_v1   <= bus.valid_in;
         r_last <= bus.valid_in & w_col_last & w_row_last;
         if (bus.valid_in) r_q <= w_q;
      end
`ifdef CONV_OUT_POOL_EN
   localparam int PW = IMG_W / 2;
   localparam int PH = IMG_H / 2;
   localparam int LW = PW > 1 ? $clog2(PW) : 1;
   logic          r_oc, r_or, r_win;
   logic [LW-1:0] r_idx;
   logic [6:0]    r_pair, w_pmax, w_wmax;
   logic          w_emit;
   logic [6:0]    r_lb [PW];
   // position of the sample now held in stage 1; r_win drops the unpaired last col/row of odd dims
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_oc  <= 1'b0;
         r_or  <= 1'b0;
         r_win <= 1'b0;
         r_idx <= '0;
      end else if (bus.valid_in) begin
         r_oc  <= r_col[0];
         r_or  <= r_row[0];
         r_win <= (32'(r_col) < 2 * PW) && (32'(r_row) < 2 * PH);
         r_idx <= LW'(r_col >> 1);
      end
   assign w_pmax = r_q > r_pair ? r_q : r_pair;
   assign w_wmax = w_pmax > r_lb[r_idx] ? w_pmax : r_lb[r_idx];
   assign w_emit = r_v1 & r_oc & r_or & r_win;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_pair <= '0;
      else if (r_v1 && !r_oc) r_pair <= r_q;
   // no reset: every entry is written on the even row before the odd row reads it
   always_ff @(posedge clk)
      if (r_v1 && r_oc && !r_or && r_win) r_lb[r_idx] <= w_pmax;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_vout <= 1'b0;
         r_dout <= '0;
         r_fd   <= 1'b0;
      end else begin
         r_vout <= w_emit;
         r_fd   <= r_v1 & r_last;
         if (w_emit) r_dout <= {1'b0, w_wmax};
      end
`else
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_vout <= 1'b0;
         r_dout <= '0;
         r_fd   <= 1'b0;
      end else begin
         r_vout <= r_v1;
         r_fd   <= r_v1 & r_last;
         if (r_v1) r_dout <= {1'b0, r_q};
      end
`endif
   assign bus.valid_out  = r_vout;
   assign bus.dout       = r_dout;
   assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_conv_out_pool.sv
// tb_conv_out_pool: scoreboard bench for conv_out_pool; expectations carry value and exact output cycle.
module tb_conv_out_pool;
   localparam int W = 12;
   localparam int H = 12;
   typedef struct {int v; int c;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   conv_out_pool_if bus ();
   conv_out_pool #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   exp_t q_out[$];
   int   q_fd[$];
   int   n_pass = 0, n_total = 0, last_v = 0;
   bit   mon_en = 1'b0;
   int   qm [H][W];
   int   br = 0, bc = 0;
   exp_t mon_e;
   bit   want;
   function automatic int mx(input int a, input int b);
      return a > b ? a : b;
   endfunction
   function automatic int model_q(input int d, input int b, input int s);
      int x;
      x = d + b;
      if (x < 0) x = 0;
      if (s > 0) x = (x + (1 << (s - 1))) >> s;
      return x > 127 ? 127 : x;
   endfunction
   // monitor: every output cycle is popped against the scoreboard; idle cycles check dout holds
   always @(negedge clk) if (mon_en && rst_n) begin
      want = q_out.size() > 0 && q_out[0].c == cyc;
      n_total++;
      if (bus.valid_out || want) begin
         if (!want) $display("FAIL out_unexpected: valid_out=1 dout=%0d at cycle %0d, none required", bus.dout, cyc);
         else begin
            mon_e = q_out.pop_front();
            last_v = mon_e.v;
            if (!bus.valid_out || bus.dout !== 8'(mon_e.v))
               $display("FAIL out_value: cycle %0d got valid_out=%b dout=%0d, required valid_out=1 dout=%0d", cyc, bus.valid_out, bus.dout, mon_e.v);
            else n_pass++;
         end
      end else if (bus.dout !== 8'(last_v))
         $display("FAIL dout_hold: cycle %0d got dout=%0d, required %0d", cyc, bus.dout, last_v);
      else n_pass++;
      want = q_fd.size() > 0 && q_fd[0] == cyc;
      if (bus.frame_done || want) begin
         n_total++;
         if (bus.frame_done && want) n_pass++;
         else $display("FAIL frame_done: cycle %0d got %b, required %b", cyc, bus.frame_done, want);
         if (want) void'(q_fd.pop_front());
      end
   end
   task automatic send(input int d, input int gap);
      int q;
      q = model_q(d, int'(bus.bias), int'(bus.shift));
      qm[br][bc] = q;
`ifdef CONV_OUT_POOL_EN
      if (br % 2 == 1 && bc % 2 == 1 && br < 2 * (H / 2) && bc < 2 * (W / 2))
         q_out.push_back('{mx(mx(qm[br-1][bc-1], qm[br-1][bc]), mx(qm[br][bc-1], q)), cyc + 2});
`else
      q_out.push_back('{q, cyc + 2});
`endif
      if (br == H - 1 && bc == W - 1) q_fd.push_back(cyc + 2);
      if (bc == W - 1) begin
         bc = 0;
         br = br == H - 1 ? 0 : br + 1;
      end else bc++;
      bus.valid_in = 1'b1;
      bus.din = 18'(d);
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask
   task automatic send_frame(input bit pattern, input int val, input int gap);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send(pattern ? ((r % 2 == 1) ? 100 : 0) + c : val, gap);
   endtask
   task automatic drain();
      repeat (4) begin @(posedge clk); #1; end
      n_total++;
      if (q_out.size() != 0 || q_fd.size() != 0)
         $display("FAIL drain: %0d outputs and %0d frame_done still pending, required 0", q_out.size(), q_fd.size());
      else n_pass++;
   endtask
   task automatic test_reset();
      bus.valid_in = 1'b0;
      bus.din = '0;
      bus.bias = '0;
      bus.shift = '0;
      repeat (3) begin @(posedge clk); #1; end
      n_total += 3;
      if (bus.valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b, required 0", bus.valid_out); else n_pass++;
      if (bus.dout !== 8'd0) $display("FAIL reset_dout: got %0d, required 0", bus.dout); else n_pass++;
      if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done); else n_pass++;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
   endtask
   task automatic test_constant();
      bus.bias = 8'sd0;
      bus.shift = 4'd0;
      send_frame(1'b0, 9, 0);
      drain();
   endtask
   task automatic test_relu_round();
      int d [4] = '{-50, 10, 9, 1000};
      int b [4] = '{0, 0, -3, 0};
      int s [4] = '{0, 2, 1, 2};
      for (int i = 0; i < 4; i++) begin
         bus.bias = 8'(b[i]);
         bus.shift = 4'(s[i]);
         send_frame(1'b0, d[i], 0);
         drain();
      end
      bus.bias = 8'sd0;
      bus.shift = 4'd0;
   endtask
   task automatic test_pool_pattern();
      send_frame(1'b1, 0, 0);
      drain();
   endtask
   task automatic test_gaps();
      send_frame(1'b1, 0, 1);
      drain();
   endtask
   task automatic test_reset_midframe();
      for (int i = 0; i < 30; i++) send(((i / W) % 2 == 1 ? 100 : 0) + i % W, 0);
      rst_n = 1'b0;
      #2;
      n_total += 3;
      if (bus.valid_out !== 1'b0) $display("FAIL midreset_valid_out: got %b, required 0", bus.valid_out); else n_pass++;
      if (bus.dout !== 8'd0) $display("FAIL midreset_dout: got %0d, required 0", bus.dout); else n_pass++;
      if (bus.frame_done !== 1'b0) $display("FAIL midreset_frame_done: got %b, required 0", bus.frame_done); else n_pass++;
      mon_en = 1'b0;
      q_out.delete();
      q_fd.delete();
      br = 0;
      bc = 0;
      last_v = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      send_frame(1'b1, 0, 0);
      drain();
   endtask
   initial begin
      test_reset();
      test_constant();
      test_relu_round();
      test_pool_pattern();
      test_gaps();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
